// File: rtl/pulse_bridge_pkg.sv
// Shared constants and helpers for the pulse rate bridge.
package pulse_bridge_pkg;

    localparam int unsigned MODE_COUNT = 0;
    localparam int unsigned MODE_MERGE = 1;

    // Largest backlog a CNT_W-bit pending counter can hold.
    function automatic int unsigned pend_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_bridge_chan.sv
// One pulse channel: pending backlog, stretched output pulse, busy and sticky overflow.
module pulse_bridge_chan
    import pulse_bridge_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned MODE  = MODE_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    input  logic slow_tick,
    input  logic ovf_clr,
    output logic pulse_out,
    output logic busy,
    output logic overflow
);

    // MERGE mode caps the backlog at one event so extra pulses collapse.
    localparam logic [CNT_W:0] CAP = (MODE == MODE_MERGE) ? (CNT_W+1)'(1)
                                                          : (CNT_W+1)'(pend_max(CNT_W));

    logic [CNT_W-1:0] pend_q, pend_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   avail;
    logic             drop;

    always_comb begin
        avail  = {1'b0, pend_q} + {{CNT_W{1'b0}}, pulse_in};
        pend_d = pend_q;
        out_d  = out_q;
        drop   = 1'b0;
        if (slow_tick) begin
            if (avail != '0) begin
                out_d  = 1'b1;
                pend_d = CNT_W'(avail - (CNT_W+1)'(1));
            end else begin
                out_d  = 1'b0;
                pend_d = '0;
            end
        end else if (avail > CAP) begin
            pend_d = CNT_W'(CAP);
            drop   = (MODE == MODE_COUNT);
        end else begin
            pend_d = CNT_W'(avail);
        end
        ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        busy_d = (pend_d != '0) || out_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pulse_out = out_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/pulse_rate_bridge.sv
// Multi-channel fast-to-slow pulse rate converter; one independent channel per pulse input.
module pulse_rate_bridge
    import pulse_bridge_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned MODE   = MODE_COUNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pulse_in,
    input  logic              slow_tick,
    input  logic              ovf_clr,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overflow
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pulse_bridge_chan #(
            .CNT_W (CNT_W),
            .MODE  (MODE)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .pulse_in  (pulse_in[i]),
            .slow_tick (slow_tick),
            .ovf_clr   (ovf_clr),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .overflow  (overflow[i])
        );
    end

endmodule

// File: tb/tb_pulse_rate_bridge.sv
// Directed bench for pulse_rate_bridge: COUNT and MERGE instances checked against a backlog model.
module tb_pulse_rate_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slow_tick = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] pulse_in = 4'b0000;
    logic [3:0] out0, busy0, ovf0;
    logic [3:0] out1, busy1, ovf1;

    always #5 clk = ~clk;

    pulse_rate_bridge #(.NUM_CH(4), .CNT_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .slow_tick(slow_tick),
        .ovf_clr(ovf_clr), .pulse_out(out0), .busy(busy0), .overflow(ovf0)
    );

    pulse_rate_bridge #(.NUM_CH(4), .CNT_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .slow_tick(slow_tick),
        .ovf_clr(ovf_clr), .pulse_out(out1), .busy(busy1), .overflow(ovf1)
    );

    // Model: index 0 = COUNT instance (capacity 3), index 1 = MERGE instance (capacity 1).
    int m_pend [2][4];
    bit m_out  [2][4];
    bit m_busy [2][4];
    bit m_ovf  [2][4];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        for (int md = 0; md < 2; md++) begin
            for (int ch = 0; ch < 4; ch++) begin
                int a;
                int cap;
                bit lost;
                cap  = (md == 0) ? 3 : 1;
                a    = m_pend[md][ch] + int'(pulse_in[ch]);
                lost = 1'b0;
                if (!rst_n) begin
                    m_pend[md][ch] = 0;
                    m_out[md][ch]  = 1'b0;
                    m_ovf[md][ch]  = 1'b0;
                end else begin
                    if (slow_tick) begin
                        m_out[md][ch]  = (a > 0);
                        m_pend[md][ch] = (a > 0) ? a - 1 : 0;
                    end else if (a > cap) begin
                        m_pend[md][ch] = cap;
                        lost = (md == 0);
                    end else begin
                        m_pend[md][ch] = a;
                    end
                    if (lost)
                        m_ovf[md][ch] = 1'b1;
                    else if (ovf_clr)
                        m_ovf[md][ch] = 1'b0;
                end
                m_busy[md][ch] = (m_pend[md][ch] != 0) || m_out[md][ch];
            end
        end
        if (!rst_n) m_valid = 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int hi0 [4];
    int hi1 [4];

    function automatic logic [3:0] mv(input int md, input int kind);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++)
            v[ch] = (kind == 0) ? m_out[md][ch] : (kind == 1) ? m_busy[md][ch] : m_ovf[md][ch];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("count.pulse_out", out0,  mv(0, 0));
        chk("count.busy",      busy0, mv(0, 1));
        chk("count.overflow",  ovf0,  mv(0, 2));
        chk("merge.pulse_out", out1,  mv(1, 0));
        chk("merge.busy",      busy1, mv(1, 1));
        chk("merge.overflow",  ovf1,  mv(1, 2));
    endtask

    // Inputs change at the falling edge; the consumer samples pulse_out during each tick cycle.
    task automatic cyc(input logic [3:0] p, input logic t, input logic c, input logic r);
        pulse_in  = p;
        slow_tick = t;
        ovf_clr   = c;
        rst_n     = r;
        #1;
        if (t && r) begin
            for (int ch = 0; ch < 4; ch++) begin
                hi0[ch] += int'(out0[ch]);
                hi1[ch] += int'(out1[ch]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (m_valid) compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(4'b0000, (k % 3) == 2, 1'b0, 1'b1);
    endtask

    initial begin
        int h;
        for (int ch = 0; ch < 4; ch++) begin
            hi0[ch] = 0;
            hi1[ch] = 0;
        end

        // Reset held with all pulses asserted
        for (int k = 0; k < 3; k++) cyc(4'b1111, k == 1, 1'b0, 1'b0);
        chk("rst.pulse_out", out0,  4'b0000);
        chk("rst.busy",      busy0, 4'b0000);
        chk("rst.overflow",  ovf0,  4'b0000);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("rel.busy",      busy0, 4'b1111);
        chk("rel.pulse_out", out0,  4'b0000);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("rel.tick1.out", out0, 4'b1111);
        chk("rel.tick1.merge_out", out1, 4'b1111);
        idle(3);
        chk("rel.drained.out",  out0,  4'b0000);
        chk("rel.drained.busy", busy0, 4'b0000);

        // Single pulse on ch0 between ticks
        h = hi0[0];
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("single.start", out0, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("single.hold", out0, 4'b0001);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("single.end.out",  out0,  4'b0000);
        chk("single.end.busy", busy0, 4'b0000);
        idle(3);
        chkn("single.samples", hi0[0] - h, 1);

        // Five pulses on ch1 with no tick: saturate at 3 and drop two
        h = hi0[1];
        for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        chk("sat.no_ovf_yet", ovf0, 4'b0000);
        chkn("sat.model_pend", m_pend[0][1], 3);
        cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        chk("sat.ovf",      ovf0,  4'b0010);
        chk("sat.busy",     busy0, 4'b0010);
        chk("sat.out",      out0,  4'b0000);
        chk("sat.merge_ovf", ovf1, 4'b0000);
        chkn("sat.merge_pend", m_pend[1][1], 1);
        begin
            int h1;
            h1 = hi1[1];
            idle(15);
            chkn("sat.samples", hi0[1] - h, 3);
            chkn("sat.merge_samples", hi1[1] - h1, 1);
        end
        chk("sat.ovf_sticky", ovf0, 4'b0010);
        cyc(4'b0000, 1'b0, 1'b1, 1'b1);
        chk("sat.ovf_clr", ovf0, 4'b0000);
        for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b1, 1'b1);
        chk("sat.set_beats_clr", ovf0, 4'b0010);
        cyc(4'b0000, 1'b0, 1'b1, 1'b1);
        chk("sat.clr_again", ovf0, 4'b0000);
        idle(12);
        chk("sat.drained", busy0, 4'b0000);

        // Pulse on ch2 coinciding with a tick
        cyc(4'b0100, 1'b1, 1'b0, 1'b1);
        chk("sametick.out",  out0,  4'b0100);
        chk("sametick.busy", busy0, 4'b0100);
        chkn("sametick.pend", m_pend[0][2], 0);
        idle(3);
        chk("sametick.end", out0, 4'b0000);

        // Four pulses on ch3 between ticks: MERGE gives one interval, COUNT keeps three
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        begin
            int h0, h1;
            h0 = hi0[3];
            h1 = hi1[3];
            for (int k = 0; k < 4; k++) cyc(4'b1000, 1'b0, 1'b0, 1'b1);
            chk("merge4.ovf", ovf1, 4'b0000);
            chk("merge4.count_ovf", ovf0, 4'b1000);
            idle(9);
            chkn("merge4.samples", hi1[3] - h1, 1);
            idle(6);
            chkn("merge4.count_samples", hi0[3] - h0, 3);
        end
        cyc(4'b0000, 1'b0, 1'b1, 1'b1);
        chk("merge4.clr", ovf0, 4'b0000);

        // Reset while ch0 is mid-delivery with backlog 2
        for (int k = 0; k < 3; k++) cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chkn("midrst.pend", m_pend[0][0], 2);
        chk("midrst.out_before", out0, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("midrst.out",  out0,  4'b0000);
        chk("midrst.busy", busy0, 4'b0000);
        chk("midrst.ovf",  ovf0,  4'b0000);
        chk("midrst.merge_out", out1, 4'b0000);
        h = hi0[0];
        idle(12);
        chkn("midrst.no_residual", hi0[0] - h, 0);
        chk("midrst.final_out", out0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
